clocks2: RTL and testbench

//  - Ten-phase machine-cycle timing generator for the D3-28 core.
//  - Divides the crystal clock into ten sequential, active-low phase strobes tn[10:1].
//  - Also derives the ROM strobe and the DRAM RAS/column-address strobes.
//  - The phase strobes drive the I/O, ALU and memory blocks; tn[10] also serves as UAPZU_n.

---
 rtl/clocks2.sv | 68 ++++++
 tb/tb_clocks2.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/clocks2.sv
// Ten-phase machine-cycle timing generator: divides xtal_in into ten active-low
// phase strobes plus ROM, RAS and column-address strobes, all registered.
module clocks2 #(
  parameter int PHASE_DIV = 4
) (
  input  logic        xtal_in,
  input  logic        init,
  output logic [10:1] tn,
  output logic        t_romn,
  output logic        A_stolb,
  output logic        t_RASn
);

  localparam int PD_W = (PHASE_DIV > 2) ? $clog2(PHASE_DIV) : 1;
  localparam logic [PD_W-1:0] PD_LAST = PD_W'(PHASE_DIV - 1);

  logic [PD_W-1:0] pdiv, pdiv_nxt;
  logic [3:0]      ph, ph_nxt;

  function automatic logic [10:1] tn_decode(input logic [3:0] p);
    logic [10:1] d;
    for (int k = 1; k <= 10; k++) d[k] = (p != 4'(k));
    return d;
  endfunction

  function automatic logic in_window(input logic [3:0] p, input logic [3:0] lo,
                                     input logic [3:0] hi);
    return (p >= lo) && (p <= hi);
  endfunction

  always_comb begin
    ph_nxt   = ph;
    pdiv_nxt = pdiv;
    if (init) begin
      ph_nxt   = 4'd0;
      pdiv_nxt = '0;
    end else if (ph == 4'd0) begin
      ph_nxt   = 4'd1;
      pdiv_nxt = '0;
    end else if (pdiv == PD_LAST) begin
      pdiv_nxt = '0;
      ph_nxt   = (ph == 4'd10) ? 4'd1 : ph + 4'd1;
    end else begin
      pdiv_nxt = pdiv + 1'b1;
    end
  end

  // Outputs are decoded from the next-state phase so they change on the same
  // edge as the phase register, with no combinational path to the pins.
  always_ff @(posedge xtal_in) begin
    if (init) begin
      ph      <= 4'd0;
      pdiv    <= '0;
      tn      <= '1;
      t_romn  <= 1'b1;
      A_stolb <= 1'b0;
      t_RASn  <= 1'b1;
    end else begin
      ph      <= ph_nxt;
      pdiv    <= pdiv_nxt;
      tn      <= tn_decode(ph_nxt);
      t_romn  <= !in_window(ph_nxt, 4'd1, 4'd5);
      A_stolb <= in_window(ph_nxt, 4'd7, 4'd8);
      t_RASn  <= !in_window(ph_nxt, 4'd6, 4'd9);
    end
  end

endmodule

// File: tb/tb_clocks2.sv
// Bench for clocks2: PHASE_DIV=4 and PHASE_DIV=2 instances share clock and init;
// a cycle-position model queues expected strobes, popped after each edge.
module tb_clocks2;

  logic       xtal_in;
  logic       init;
  logic [9:0] tn4, tn2;
  logic       romn4, ast4, rasn4;
  logic       romn2, ast2, rasn2;

  int tests  = 0;
  int failed = 0;

  typedef struct packed {
    logic [9:0] tn;
    logic       romn;
    logic       ast;
    logic       rasn;
  } exp_t;

  exp_t q4[$];
  exp_t q2[$];
  int   cyc4 = 0;
  int   cyc2 = 0;

  clocks2 #(.PHASE_DIV(4)) dut4 (
    .xtal_in(xtal_in), .init(init), .tn(tn4),
    .t_romn(romn4), .A_stolb(ast4), .t_RASn(rasn4)
  );

  clocks2 #(.PHASE_DIV(2)) dut2 (
    .xtal_in(xtal_in), .init(init), .tn(tn2),
    .t_romn(romn2), .A_stolb(ast2), .t_RASn(rasn2)
  );

  initial begin
    xtal_in = 1'b0;
    forever #5 xtal_in = ~xtal_in;
  end

  function automatic exp_t model_out(input int cyc, input int pd);
    exp_t e;
    int   ph;
    e.tn = 10'h3FF; e.romn = 1'b1; e.ast = 1'b0; e.rasn = 1'b1;
    if (cyc > 0) begin
      ph = (cyc - 1) / pd + 1;
      e.tn[ph-1] = 1'b0;
      e.romn = !(ph >= 1 && ph <= 5);
      e.rasn = !(ph >= 6 && ph <= 9);
      e.ast  = (ph == 7 || ph == 8);
    end
    return e;
  endfunction

  function automatic int model_step(input int cyc, input int pd, input logic rst);
    if (rst)          return 0;
    if (cyc == 0)     return 1;
    if (cyc == 10*pd) return 1;
    return cyc + 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Drive init for the next edge, queue the expected result, then compare after it.
  task automatic drive(input logic v);
    exp_t e;
    init = v;
    cyc4 = model_step(cyc4, 4, v);
    cyc2 = model_step(cyc2, 2, v);
    q4.push_back(model_out(cyc4, 4));
    q2.push_back(model_out(cyc2, 2));
    @(posedge xtal_in);
    #1;
    e = q4.pop_front();
    chk("pd4_tn", {22'd0, tn4}, {22'd0, e.tn});
    chk("pd4_romn", {31'd0, romn4}, {31'd0, e.romn});
    chk("pd4_rasn", {31'd0, rasn4}, {31'd0, e.rasn});
    chk("pd4_ast", {31'd0, ast4}, {31'd0, e.ast});
    chk("pd4_lowcount", $countones(~tn4), (cyc4 > 0) ? 1 : 0);
    chk("pd4_ast_in_ras", {31'd0, ast4 & rasn4}, 32'd0);
    chk("pd4_rom_ras_disjoint", {31'd0, !romn4 & !rasn4}, 32'd0);
    e = q2.pop_front();
    chk("pd2_tn", {22'd0, tn2}, {22'd0, e.tn});
    chk("pd2_romn", {31'd0, romn2}, {31'd0, e.romn});
    chk("pd2_rasn", {31'd0, rasn2}, {31'd0, e.rasn});
    chk("pd2_ast", {31'd0, ast2}, {31'd0, e.ast});
    chk("pd2_lowcount", $countones(~tn2), (cyc2 > 0) ? 1 : 0);
  endtask

  initial begin
    init = 1'b1;
    @(negedge xtal_in);

    for (int i = 0; i < 5; i++) begin
      drive(1'b1);
      chk("reset_tn", {22'd0, tn4}, 32'h3FF);
    end

    // Three full machine cycles after release, with directed spot checks.
    for (int c = 1; c <= 120; c++) begin
      drive(1'b0);
      if (c >= 1 && c <= 4)   chk("start_tn1", {22'd0, tn4}, 32'h3FE);
      if (c == 5)             chk("phase2_tn", {22'd0, tn4}, 32'h3FD);
      if (c >= 37 && c <= 40) chk("phase10_tn", {22'd0, tn4}, 32'h1FF);
      if (c == 41)            chk("wrap_tn1", {22'd0, tn4}, 32'h3FE);
      if (c == 20)            chk("rom_last", {31'd0, romn4}, 32'd0);
      if (c == 21)            chk("rom_end", {31'd0, romn4}, 32'd1);
      if (c == 21)            chk("ras_start", {31'd0, rasn4}, 32'd0);
      if (c == 37)            chk("ras_end", {31'd0, rasn4}, 32'd1);
      if (c == 24)            chk("ast_before", {31'd0, ast4}, 32'd0);
      if (c == 25)            chk("ast_start", {31'd0, ast4}, 32'd1);
      if (c == 33)            chk("ast_end", {31'd0, ast4}, 32'd0);
      if (c == 3)             chk("pd2_phase2", {22'd0, tn2}, 32'h3FD);
      if (c == 21)            chk("pd2_wrap", {22'd0, tn2}, 32'h3FE);
    end

    // Advance to phase 6 with pdiv=2, then pulse init for one edge.
    for (int c = 1; c <= 23; c++) drive(1'b0);
    drive(1'b1);
    chk("midreset_tn", {22'd0, tn4}, 32'h3FF);
    chk("midreset_ras", {31'd0, rasn4}, 32'd1);
    for (int c = 1; c <= 5; c++) begin
      drive(1'b0);
      if (c <= 4) chk("restart_tn1", {22'd0, tn4}, 32'h3FE);
      else        chk("restart_tn2", {22'd0, tn4}, 32'h3FD);
    end

    for (int i = 0; i < 10; i++) begin
      drive(1'b1);
      chk("hold_reset_tn", {22'd0, tn4}, 32'h3FF);
      chk("hold_reset_ast", {31'd0, ast2}, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
